sd_sector_arbiter: RTL

Arbitrates single-sector read/write access to the shared SD block engine between two FAT32 requesters: requester 0 is the file-data writer, requester 1 is the FAT/directory updater that addresses sectors derived from the root-directory computation. Sector address, command and byte streams pass through a registered handshake with round-robin fairness. This replaces tristate line sharing with a synchronous, one-owner-at-a-time grant.

---
 rtl/sd_fat32_pkg.sv | 25 ++
 rtl/sd_arb_rr_pick.sv | 26 ++
 rtl/sd_sector_arbiter.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/sd_fat32_pkg.sv
// sd_fat32_pkg
// Shared definitions for the FAT32 SD sector arbiter: arbiter state
// encoding, requester index constants, the default sector address width
// and a small index-to-one-hot helper.
package sd_fat32_pkg;

  localparam int SECTOR_W_DEF = 32;

  // Requester 0 writes file data, requester 1 updates FAT/directory sectors.
  localparam int REQ_DATA = 0;
  localparam int REQ_FAT  = 1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_RELEASE   = 3'd4
  } arb_state_t;

  function automatic logic [1:0] owner_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/sd_arb_rr_pick.sv
// sd_arb_rr_pick
// Combinational two-way round-robin picker. A lone request wins outright;
// when both requesters ask, the one that did not own the engine last wins.
// Ports:
//   req        in  2  request vector
//   last_owner in  1  index of the previous owner
//   winner     out 1  index of the selected requester
//   valid      out 1  at least one request present
module sd_arb_rr_pick (
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic       winner,
  output logic       valid
);

  always_comb begin
    valid  = |req;
    winner = 1'b0;
    if (&req) begin
      winner = ~last_owner;
    end else begin
      winner = req[1];
    end
  end

endmodule

// File: rtl/sd_sector_arbiter.sv
// sd_sector_arbiter
// Grants one of two FAT32 requesters exclusive single-sector access to the
// shared SD block engine. The winner's direction and sector address are
// latched at grant time; write bytes, write-byte requests and read strobes
// are routed through the grant so only the owner sees engine traffic.
//
// Optional feature: define SD_ARB_TIMEOUT_EN to add a watchdog that aborts
// a transaction stuck in WAIT_BUSY/WAIT_DONE for TIMEOUT_CYCLES cycles and
// reports it on err instead of done.
//
// Ports:
//   sys_clk, sys_rst_n          clock, asynchronous active-low reset
//   req, req_wr                 per-requester request level and direction
//   req_sector, req_wdata       packed per-requester sector and write byte
//   grant, done, err            one-hot owner, completion/timeout pulses
//   wdata_req, rdata, rdata_vld engine byte traffic routed to the owner
//   sd_start, sd_wr, sd_sector  command to the block engine
//   sd_wdata                    owner's write byte to the engine
//   sd_wdata_req, sd_rdata,
//   sd_rdata_vld, sd_busy       engine status and byte traffic
module sd_sector_arbiter
  import sd_fat32_pkg::*;
#(
  parameter int SECTOR_W       = SECTOR_W_DEF,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic [1:0]            req,
  input  logic [1:0]            req_wr,
  input  logic [2*SECTOR_W-1:0] req_sector,
  input  logic [15:0]           req_wdata,
  output logic [1:0]            grant,
  output logic [1:0]            done,
  output logic [1:0]            err,
  output logic [1:0]            wdata_req,
  output logic [7:0]            rdata,
  output logic [1:0]            rdata_vld,
  output logic                  sd_start,
  output logic                  sd_wr,
  output logic [SECTOR_W-1:0]   sd_sector,
  output logic [7:0]            sd_wdata,
  input  logic                  sd_wdata_req,
  input  logic [7:0]            sd_rdata,
  input  logic                  sd_rdata_vld,
  input  logic                  sd_busy
);

  arb_state_t state, state_nxt;
  logic       owner;
  logic       last_owner;
  logic       pick_winner;
  logic       pick_valid;
  logic       tmo_expired;
  logic       tmo_hit;

  sd_arb_rr_pick u_pick (
    .req        (req),
    .last_owner (last_owner),
    .winner     (pick_winner),
    .valid      (pick_valid)
  );

  // Next-state logic. An engine status change takes priority over a
  // watchdog expiry landing in the same cycle.
  always_comb begin
    state_nxt = state;
    tmo_hit   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_valid) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        state_nxt = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (sd_busy) begin
          state_nxt = ST_WAIT_DONE;
        end else if (tmo_expired) begin
          state_nxt = ST_RELEASE;
          tmo_hit   = 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!sd_busy) begin
          state_nxt = ST_RELEASE;
        end else if (tmo_expired) begin
          state_nxt = ST_RELEASE;
          tmo_hit   = 1'b1;
        end
      end
      ST_RELEASE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Registered outputs: sd_start is high for the ISSUE cycle, done for the
  // RELEASE cycle; grant is held through RELEASE and drops on leaving it.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= ST_IDLE;
      grant      <= 2'b00;
      done       <= 2'b00;
      sd_start   <= 1'b0;
      sd_wr      <= 1'b0;
      sd_sector  <= '0;
      owner      <= 1'b0;
      last_owner <= 1'b1;
    end else begin
      state    <= state_nxt;
      sd_start <= (state == ST_IDLE) && pick_valid;
      done     <= 2'b00;
      if ((state == ST_IDLE) && pick_valid) begin
        owner     <= pick_winner;
        grant     <= owner_onehot(pick_winner);
        sd_wr     <= req_wr[pick_winner];
        sd_sector <= pick_winner ? req_sector[2*SECTOR_W-1:SECTOR_W]
                                 : req_sector[SECTOR_W-1:0];
      end
      if ((state_nxt == ST_RELEASE) && (state != ST_RELEASE) && !tmo_hit) begin
        done <= owner_onehot(owner);
      end
      if (state == ST_RELEASE) begin
        grant      <= 2'b00;
        last_owner <= owner;
      end
    end
  end

`ifdef SD_ARB_TIMEOUT_EN
  logic [31:0] tmo_cnt;
  logic [1:0]  err_q;

  // Watchdog restarts on every state change and only advances while the
  // engine is expected to make progress.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tmo_cnt <= '0;
      err_q   <= 2'b00;
    end else begin
      err_q <= 2'b00;
      if (state_nxt != state) begin
        tmo_cnt <= '0;
      end else if ((state == ST_WAIT_BUSY) || (state == ST_WAIT_DONE)) begin
        tmo_cnt <= tmo_cnt + 32'd1;
      end
      if (tmo_hit) begin
        err_q <= owner_onehot(owner);
      end
    end
  end

  assign tmo_expired = (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));
  assign err         = err_q;
`else
  assign tmo_expired = 1'b0;
  assign err         = 2'b00;
`endif

  // Engine byte traffic is visible only to the current owner.
  assign wdata_req = grant & {2{sd_wdata_req}};
  assign rdata_vld = grant & {2{sd_rdata_vld}};
  assign rdata     = sd_rdata;

  always_comb begin
    sd_wdata = 8'h00;
    case (grant)
      2'b01:   sd_wdata = req_wdata[REQ_DATA*8 +: 8];
      2'b10:   sd_wdata = req_wdata[REQ_FAT*8 +: 8];
      default: sd_wdata = 8'h00;
    endcase
  end

endmodule
